// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: 15-entry program register file with two decode read
// ports, architectural status, sticky halt latch and retired-instruction counter.
module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int STAT_W = 3,
  parameter int CNT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [STAT_W-1:0] W_stat_i,
  input  logic [ADDR_W-1:0] W_pc_i,
  input  logic [3:0]        W_icode_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [3:0]        W_dstE_i,
  input  logic [3:0]        W_dstM_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  output logic [DATA_W-1:0] d_rvalA_o,
  output logic [DATA_W-1:0] d_rvalB_o,
  output logic [STAT_W-1:0] Stat_o,
  output logic              cpu_halt_o,
  output logic [ADDR_W-1:0] halt_pc_o,
  output logic [STAT_W-1:0] halt_stat_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [STAT_W-1:0] STAT_BUB = STAT_W'(0);
  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_HLT = STAT_W'(2);
  localparam logic [STAT_W-1:0] STAT_ADR = STAT_W'(3);
  localparam logic [STAT_W-1:0] STAT_INS = STAT_W'(4);
  localparam logic [3:0]        NREG     = 4'hF;

  logic [DATA_W-1:0] regs_reg [15];
  logic              halt_reg;
  logic [ADDR_W-1:0] halt_pc_reg;
  logic [STAT_W-1:0] halt_stat_reg;
  logic [CNT_W-1:0]  retired_reg;

  logic we_ok;
  logic is_exc;
  logic [3:0] unused_icode;

  // icode is carried for trace only and never influences state
  assign unused_icode = W_icode_i;

  assign we_ok  = !halt_reg && (W_stat_i == STAT_BUB || W_stat_i == STAT_AOK);
  assign is_exc = (W_stat_i == STAT_HLT) || (W_stat_i == STAT_ADR) ||
                  (W_stat_i == STAT_INS);

  // Flop-based storage so every register clears on reset; port M has priority.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_reg
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          regs_reg[gi] <= '0;
        end else if (we_ok && W_dstM_i == 4'(gi)) begin
          regs_reg[gi] <= W_valM_i;
        end else if (we_ok && W_dstE_i == 4'(gi)) begin
          regs_reg[gi] <= W_valE_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halt_reg      <= 1'b0;
      halt_pc_reg   <= '0;
      halt_stat_reg <= '0;
      retired_reg   <= '0;
    end else if (!halt_reg) begin
      if (is_exc) begin
        halt_reg      <= 1'b1;
        halt_pc_reg   <= W_pc_i;
        halt_stat_reg <= W_stat_i;
      end
      if (W_stat_i == STAT_AOK) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // No write-to-read bypass: decode forwards from W itself.
  assign d_rvalA_o = (d_srcA_i == NREG) ? '0 : regs_reg[d_srcA_i];
  assign d_rvalB_o = (d_srcB_i == NREG) ? '0 : regs_reg[d_srcB_i];

  assign Stat_o      = (W_stat_i == STAT_BUB) ? STAT_AOK : W_stat_i;
  assign cpu_halt_o  = halt_reg;
  assign halt_pc_o   = halt_pc_reg;
  assign halt_stat_o = halt_stat_reg;
  assign retired_o   = retired_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; inputs change and outputs are sampled
// on the falling edge, writes commit on the rising edge.
module tb_writeback_regfile;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  W_stat_i;
  logic [63:0] W_pc_i;
  logic [3:0]  W_icode_i;
  logic [63:0] W_valE_i;
  logic [63:0] W_valM_i;
  logic [3:0]  W_dstE_i;
  logic [3:0]  W_dstM_i;
  logic [3:0]  d_srcA_i;
  logic [3:0]  d_srcB_i;
  logic [63:0] d_rvalA_o;
  logic [63:0] d_rvalB_o;
  logic [2:0]  Stat_o;
  logic        cpu_halt_o;
  logic [63:0] halt_pc_o;
  logic [2:0]  halt_stat_o;
  logic [63:0] retired_o;

  int errors = 0;
  int checks = 0;

  writeback_regfile dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .W_stat_i(W_stat_i), .W_pc_i(W_pc_i), .W_icode_i(W_icode_i),
    .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
    .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i),
    .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
    .Stat_o(Stat_o), .cpu_halt_o(cpu_halt_o),
    .halt_pc_o(halt_pc_o), .halt_stat_o(halt_stat_o),
    .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic w_drive(input logic [2:0] stat, input logic [63:0] pc,
                         input logic [3:0] dste, input logic [63:0] vale,
                         input logic [3:0] dstm, input logic [63:0] valm);
    W_stat_i = stat; W_pc_i = pc; W_dstE_i = dste; W_valE_i = vale;
    W_dstM_i = dstm; W_valM_i = valm;
  endtask

  task automatic bubble();
    w_drive(3'd0, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i = 1'b0;
    W_icode_i = 4'h1;
    d_srcA_i = 4'hF;
    d_srcB_i = 4'hF;
    bubble();
    @(negedge clk_i);
    @(negedge clk_i);
    d_srcA_i = 4'd3;
    d_srcB_i = 4'd14;
    #1;
    check("rst_rvalA", d_rvalA_o, 64'h0);
    check("rst_rvalB", d_rvalB_o, 64'h0);
    check("rst_halt", {63'h0, cpu_halt_o}, 64'h0);
    check("rst_retired", retired_o, 64'h0);
    check("rst_halt_pc", halt_pc_o, 64'h0);
    rst_n_i = 1'b1;

    // single write through port E
    @(negedge clk_i);
    w_drive(3'd1, 64'h10, 4'd3, 64'h1234, 4'hF, 64'h0);
    #1 check("aok_stat", {61'h0, Stat_o}, 64'd1);
    step();
    bubble();
    d_srcA_i = 4'd3;
    #1 check("wr_rvalA_r3", d_rvalA_o, 64'h1234);
    check("wr_retired", retired_o, 64'd1);

    // collision: valM wins, then independent dual write
    @(negedge clk_i);
    w_drive(3'd1, 64'h18, 4'd4, 64'h10, 4'd4, 64'h20);
    step();
    w_drive(3'd1, 64'h20, 4'd2, 64'hA, 4'd5, 64'hB);
    d_srcA_i = 4'd4;
    #1 check("collide_r4", d_rvalA_o, 64'h20);
    step();
    bubble();
    d_srcA_i = 4'd2;
    d_srcB_i = 4'd5;
    #1 check("dual_r2", d_rvalA_o, 64'hA);
    check("dual_r5", d_rvalB_o, 64'hB);
    check("dual_retired", retired_o, 64'd3);

    // bubble: no count, Stat reads AOK, NREG reads zero
    #1 check("bub_stat", {61'h0, Stat_o}, 64'd1);
    step();
    d_srcA_i = 4'hF;
    #1 check("bub_retired", retired_o, 64'd3);
    check("nreg_read", d_rvalA_o, 64'h0);
    check("bub_r5_kept", d_rvalB_o, 64'hB);

    // same-cycle read of a register being written returns the old value
    @(negedge clk_i);
    w_drive(3'd1, 64'h28, 4'd7, 64'h1, 4'hF, 64'h0);
    step();
    w_drive(3'd1, 64'h30, 4'd7, 64'h2, 4'hF, 64'h0);
    d_srcB_i = 4'd7;
    #1 check("rw_same_cycle", d_rvalB_o, 64'h1);
    step();
    bubble();
    #1 check("rw_next_cycle", d_rvalB_o, 64'h2);
    check("rw_retired", retired_o, 64'd5);

    // halt latch; halting instruction is not counted
    @(negedge clk_i);
    w_drive(3'd2, 64'h40, 4'hF, 64'h0, 4'hF, 64'h0);
    #1 check("hlt_stat_out", {61'h0, Stat_o}, 64'd2);
    step();
    w_drive(3'd3, 64'h80, 4'd1, 64'h99, 4'hF, 64'h0);
    #1 check("hlt_flag", {63'h0, cpu_halt_o}, 64'd1);
    check("hlt_pc", halt_pc_o, 64'h40);
    check("hlt_statcode", {61'h0, halt_stat_o}, 64'd2);
    check("hlt_retired", retired_o, 64'd5);
    step();
    w_drive(3'd1, 64'h88, 4'd2, 64'h77, 4'hF, 64'h0);
    d_srcA_i = 4'd1;
    #1 check("post_hlt_r1", d_rvalA_o, 64'h0);
    check("post_hlt_pc", halt_pc_o, 64'h40);
    check("post_hlt_stat", {61'h0, halt_stat_o}, 64'd2);
    step();
    bubble();
    d_srcA_i = 4'd2;
    #1 check("post_hlt_aok_r2", d_rvalA_o, 64'hA);
    check("post_hlt_aok_cnt", retired_o, 64'd5);

    // asynchronous reset in mid-cycle
    #2 rst_n_i = 1'b0;
    d_srcA_i = 4'd4;
    d_srcB_i = 4'd7;
    #1 check("arst_r4", d_rvalA_o, 64'h0);
    check("arst_r7", d_rvalB_o, 64'h0);
    check("arst_halt", {63'h0, cpu_halt_o}, 64'h0);
    check("arst_retired", retired_o, 64'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // ADR exception: write suppressed, halt latched with ADR
    w_drive(3'd1, 64'h100, 4'hF, 64'h0, 4'd6, 64'h11);
    step();
    w_drive(3'd3, 64'h108, 4'hF, 64'h0, 4'd6, 64'h55);
    step();
    bubble();
    d_srcA_i = 4'd6;
    #1 check("adr_r6_kept", d_rvalA_o, 64'h11);
    check("adr_halt", {63'h0, cpu_halt_o}, 64'd1);
    check("adr_statcode", {61'h0, halt_stat_o}, 64'd3);
    check("adr_pc", halt_pc_o, 64'h108);
    check("adr_retired", retired_o, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
